// File: rtl/sha256_state_acc.sv
// SHA-256 chaining-state accumulator: folds compression working variables into
// the chaining value per word, tracks the first-pass midstate and the final digest.

module sha256_word_add #(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum
);
  // Modulo 2^WORD_W; no carry leaves the word.
  assign sum = a + b;
endmodule

module sha256_state_acc #(
  parameter int WORD_W      = 32,
  parameter int NWORDS      = 8,
  parameter int DOUBLE_HASH = 1,
  parameter logic [NWORDS*WORD_W-1:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     mid_load,
  input  logic [NWORDS*WORD_W-1:0] mid_in,
  input  logic                     acc_valid,
  input  logic                     last_block,
  input  logic [NWORDS*WORD_W-1:0] work_in,
  output logic                     acc_ready,
  output logic [NWORDS*WORD_W-1:0] h_state,
  output logic                     pass,
  output logic [NWORDS*WORD_W-1:0] midstate,
  output logic [NWORDS*WORD_W-1:0] digest,
  output logic                     digest_valid,
  output logic [15:0]              blk_cnt,
  output logic                     err
);
  localparam int HW = NWORDS*WORD_W;

  typedef enum logic [1:0] {IDLE, HASH1, HASH2, DONE} state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   acc_sum;
  logic [HW-1:0]   h_nxt, mid_nxt, dig_nxt;
  logic            dv_nxt, pass_nxt, err_nxt;
  logic [15:0]     cnt_nxt, cnt_inc;

  // One adder per chaining word; word 0 sits in the MSBs.
  for (genvar i = 0; i < NWORDS; i++) begin : g_word
    sha256_word_add #(.WORD_W(WORD_W)) u_add (
      .a   (h_state[i*WORD_W +: WORD_W]),
      .b   (work_in[i*WORD_W +: WORD_W]),
      .sum (acc_sum[i*WORD_W +: WORD_W])
    );
  end

  assign acc_ready = (state == HASH1) || (state == HASH2);
  assign cnt_inc   = (blk_cnt == 16'hFFFF) ? blk_cnt : blk_cnt + 16'd1;

  always_comb begin
    state_nxt = state;
    h_nxt     = h_state;
    mid_nxt   = midstate;
    dig_nxt   = digest;
    dv_nxt    = digest_valid;
    pass_nxt  = pass;
    cnt_nxt   = blk_cnt;
    err_nxt   = err;
    if (init) begin
      // init beats a coincident acc_valid, which is dropped silently.
      state_nxt = HASH1;
      h_nxt     = mid_load ? mid_in : IV;
      cnt_nxt   = 16'd0;
      pass_nxt  = 1'b0;
      dv_nxt    = 1'b0;
      err_nxt   = 1'b0;
    end else if (acc_valid) begin
      case (state)
        IDLE, DONE: err_nxt = 1'b1;
        HASH1: begin
          cnt_nxt = cnt_inc;
          if (blk_cnt == 16'd0) mid_nxt = acc_sum;
          if (!last_block) begin
            h_nxt = acc_sum;
          end else if (DOUBLE_HASH != 0) begin
            dig_nxt   = acc_sum;
            h_nxt     = IV;
            pass_nxt  = 1'b1;
            state_nxt = HASH2;
          end else begin
            dig_nxt   = acc_sum;
            h_nxt     = acc_sum;
            dv_nxt    = 1'b1;
            state_nxt = DONE;
          end
        end
        HASH2: begin
          cnt_nxt   = cnt_inc;
          dig_nxt   = acc_sum;
          dv_nxt    = 1'b1;
          state_nxt = DONE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      h_state      <= IV;
      midstate     <= IV;
      digest       <= '0;
      digest_valid <= 1'b0;
      pass         <= 1'b0;
      blk_cnt      <= 16'd0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      h_state      <= h_nxt;
      midstate     <= mid_nxt;
      digest       <= dig_nxt;
      digest_valid <= dv_nxt;
      pass         <= pass_nxt;
      blk_cnt      <= cnt_nxt;
      err          <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sha256_state_acc.sv
// Bench for sha256_state_acc: single- and double-hash instances share stimulus and
// are compared every cycle against a job-level model plus a real SHA-256 compression.

module tb_sha256_state_acc;
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_D =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] ABC_DD =
    256'h4f8b42c2_2dd3729b_519ba6f6_8d2da7cc_5b2d606d_05daed5a_d5128cc0_3e6c6358;
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, init, mid_load, acc_valid, last_block;
  logic [255:0] mid_in, work_in;

  logic         s_ready, s_pass, s_dv, s_err, d_ready, d_pass, d_dv, d_err;
  logic [255:0] s_h, s_mid, s_dig, d_h, d_mid, d_dig;
  logic [15:0]  s_cnt, d_cnt;

  sha256_state_acc #(.DOUBLE_HASH(0)) u_single (
    .clk(clk), .rst(rst), .init(init), .mid_load(mid_load), .mid_in(mid_in),
    .acc_valid(acc_valid), .last_block(last_block), .work_in(work_in),
    .acc_ready(s_ready), .h_state(s_h), .pass(s_pass), .midstate(s_mid),
    .digest(s_dig), .digest_valid(s_dv), .blk_cnt(s_cnt), .err(s_err));

  sha256_state_acc #(.DOUBLE_HASH(1)) u_double (
    .clk(clk), .rst(rst), .init(init), .mid_load(mid_load), .mid_in(mid_in),
    .acc_valid(acc_valid), .last_block(last_block), .work_in(work_in),
    .acc_ready(d_ready), .h_state(d_h), .pass(d_pass), .midstate(d_mid),
    .digest(d_dig), .digest_valid(d_dv), .blk_cnt(d_cnt), .err(d_err));

  // Job phase: 0 idle, 1 first hash, 2 second hash, 3 done.
  typedef struct {
    int           ph;
    logic [255:0] h, mid, dig;
    logic         dv, pass, err;
    logic [15:0]  cnt;
  } mst_t;

  mst_t m0, m1;
  int   n_pass = 0, n_total = 0;

  function automatic logic [31:0] rotr(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Full SHA-256 compression; returns final working variables a..h (a in MSBs).
  function automatic logic [255:0] compress(logic [255:0] hin, logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = v[i];
    return r;
  endfunction

  function automatic logic [255:0] wadd(logic [255:0] a, logic [255:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = a[255-32*i -: 32] + b[255-32*i -: 32];
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic mst_t model(mst_t s, bit dh, logic r, logic i, logic ml, logic [255:0] mi,
                                 logic av, logic lb, logic [255:0] w);
    mst_t n = s;
    logic [255:0] sum = wadd(s.h, w);
    logic [15:0] inc = (s.cnt == 16'hFFFF) ? s.cnt : s.cnt + 16'd1;
    if (r) begin
      n.ph = 0; n.h = IV; n.mid = IV; n.dig = '0;
      n.dv = 0; n.pass = 0; n.cnt = 0; n.err = 0;
    end else if (i) begin
      n.ph = 1; n.h = ml ? mi : IV; n.cnt = 0; n.pass = 0; n.dv = 0; n.err = 0;
    end else if (av) begin
      if (s.ph == 0 || s.ph == 3) n.err = 1;
      else if (s.ph == 1) begin
        n.cnt = inc;
        if (s.cnt == 0) n.mid = sum;
        if (!lb) n.h = sum;
        else begin
          n.dig = sum;
          if (dh) begin n.h = IV; n.pass = 1; n.ph = 2; end
          else begin n.h = sum; n.dv = 1; n.ph = 3; end
        end
      end else begin
        n.cnt = inc; n.dig = sum; n.dv = 1; n.ph = 3;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_all(input string p, input mst_t m, input logic rdy, input logic [255:0] h,
                         input logic ps, input logic [255:0] mid, input logic [255:0] dig,
                         input logic dv, input logic [15:0] cnt, input logic e);
    chk({p, ".acc_ready"}, 256'(rdy), 256'(m.ph == 1 || m.ph == 2));
    chk({p, ".h_state"}, h, m.h);
    chk({p, ".pass"}, 256'(ps), 256'(m.pass));
    chk({p, ".midstate"}, mid, m.mid);
    chk({p, ".digest"}, dig, m.dig);
    chk({p, ".digest_valid"}, 256'(dv), 256'(m.dv));
    chk({p, ".blk_cnt"}, 256'(cnt), 256'(m.cnt));
    chk({p, ".err"}, 256'(e), 256'(m.err));
  endtask

  task automatic step(input logic r, input logic i, input logic ml, input logic [255:0] mi,
                      input logic av, input logic lb, input logic [255:0] w);
    rst = r; init = i; mid_load = ml; mid_in = mi;
    acc_valid = av; last_block = lb; work_in = w;
    @(posedge clk);
    m0 = model(m0, 1'b0, r, i, ml, mi, av, lb, w);
    m1 = model(m1, 1'b1, r, i, ml, mi, av, lb, w);
    #1;
    chk_all("single", m0, s_ready, s_h, s_pass, s_mid, s_dig, s_dv, s_cnt, s_err);
    chk_all("double", m1, d_ready, d_h, d_pass, d_mid, d_dig, d_dv, d_cnt, d_err);
  endtask

  initial begin
    logic [511:0] abc_blk, blk2;
    logic [255:0] wv1, wv2, mi, saved_mid;

    abc_blk = {32'h61626380, 416'b0, 64'd24};
    blk2    = {ABC_D, 32'h80000000, 160'b0, 64'd256};
    wv1     = compress(IV, abc_blk);
    wv2     = compress(IV, blk2);

    // Reset state, then protocol errors and init/acc_valid collision.
    step(1, 0, 0, '0, 0, 0, '0);
    chk("rst.digest_zero", s_dig, '0);
    step(0, 0, 0, '0, 1, 0, rnd256());
    chk("idle_acc.err", 256'(d_err), 256'(1));
    step(0, 1, 0, '0, 0, 0, '0);
    chk("init.err_clear", 256'(d_err), 256'(0));
    step(0, 1, 0, '0, 1, 1, rnd256());
    chk("init_acc.h_iv", d_h, IV);

    // "abc": single-hash digest and first pass of the double hash.
    step(0, 1, 0, '0, 0, 0, '0);
    step(0, 0, 0, '0, 1, 1, wv1);
    chk("abc.single_digest", s_dig, ABC_D);
    chk("abc.single_dv", 256'(s_dv), 256'(1));
    chk("abc.double_pass", 256'(d_pass), 256'(1));
    step(0, 0, 0, '0, 1, 0, wv2);
    chk("abc.double_digest", d_dig, ABC_DD);
    step(0, 0, 0, '0, 0, 0, '0);
    chk("done.hold", d_dig, ABC_DD);

    // Per-word wrap with no carry into word 1.
    mi = rnd256();
    mi[255:224] = 32'hFFFFFFFF;
    step(0, 1, 1, mi, 0, 0, '0);
    step(0, 0, 0, '0, 1, 0, {32'h1, 224'b0});
    chk("wrap.word0", 256'(d_h[255:224]), 256'(0));
    chk("wrap.rest", 256'(d_h[223:0]), 256'(mi[223:0]));

    // Two-block job: midstate captured after block 1 and held through HASH2.
    step(0, 1, 1, rnd256(), 0, 0, '0);
    step(0, 0, 0, '0, 1, 0, rnd256());
    saved_mid = d_h;
    chk("two.mid_eq_h", d_mid, saved_mid);
    step(0, 0, 0, '0, 1, 1, rnd256());
    step(0, 0, 0, '0, 1, 0, rnd256());
    chk("two.mid_held", d_mid, saved_mid);

    // Reset inside HASH2 with acc_valid high.
    step(0, 1, 0, '0, 0, 0, '0);
    step(0, 0, 0, '0, 1, 1, rnd256());
    step(1, 0, 0, '0, 1, 0, rnd256());
    chk("rst_h2.digest", d_dig, '0);
    chk("rst_h2.h_iv", d_h, IV);

    // Random traffic.
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
           rnd256(), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, rnd256());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
